// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its instruction sequencer:
// opcode values, datapath width and sequencer state encoding.
package alu_pkg;

  localparam int ALU_W = 4;

  localparam logic [3:0] OP_NOT   = 4'd0;
  localparam logic [3:0] OP_AND   = 4'd1;
  localparam logic [3:0] OP_NAND  = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_NOR   = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_XNOR  = 4'd6;
  localparam logic [3:0] OP_SHIFT = 4'd7;
  localparam logic [3:0] OP_ADD   = 4'd8;
  localparam logic [3:0] OP_SUB   = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_DIV   = 4'd11;
  localparam logic [3:0] OP_LDI   = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB1  = 2'd2,
    ST_WB2  = 2'd3
  } state_e;

  function automatic logic is_illegal(input logic [3:0] op);
    return op > OP_LDI;
  endfunction

  function automatic logic writes_two(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 4-bit ALU: logic ops, left shift, wrapping add/sub,
// full-width product and quotient/remainder (zero when y is zero).
module alu
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0]   x,
  input  logic [ALU_W-1:0]   y,
  input  logic [3:0]         opcode,
  output logic [ALU_W-1:0]   o,
  output logic [2*ALU_W-1:0] product,
  output logic [ALU_W-1:0]   remainder
);

  logic [ALU_W-1:0] quotient;

  always_comb begin
    product   = (2*ALU_W)'(x) * (2*ALU_W)'(y);
    quotient  = (y == '0) ? '0 : x / y;
    remainder = (y == '0) ? '0 : x % y;
    o         = '0;
    case (opcode)
      OP_NOT:   o = ~x;
      OP_AND:   o = x & y;
      OP_NAND:  o = ~(x & y);
      OP_OR:    o = x | y;
      OP_NOR:   o = ~(x | y);
      OP_XOR:   o = x ^ y;
      OP_XNOR:  o = ~(x ^ y);
      OP_SHIFT: o = x << y;
      OP_ADD:   o = x + y;
      OP_SUB:   o = x - y;
      OP_MUL:   o = product[ALU_W-1:0];
      OP_DIV:   o = quotient;
      default:  o = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Single-issue instruction sequencer: latches operands at accept, runs the
// ALU for one cycle, then writes one or two registers back.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter  int NREGS = 4,
  localparam int RA_W  = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [RA_W-1:0]  in_dst,
  input  logic [RA_W-1:0]  in_src_a,
  input  logic [RA_W-1:0]  in_src_b,
  input  logic [3:0]       in_imm,
  input  logic [RA_W-1:0]  rd_addr,
  output logic [3:0]       rd_data,
  output logic             done,
  output logic [3:0]       result,
  output logic             err_div0,
  output logic             err_illegal
);

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [RA_W-1:0]   dst_q, dst_d;
  logic [ALU_W-1:0]  imm_q, imm_d;
  logic [ALU_W-1:0]  a_q, a_d;
  logic [ALU_W-1:0]  b_q, b_d;
  logic [ALU_W-1:0]  res_lo_q, res_lo_d;
  logic [ALU_W-1:0]  res_hi_q, res_hi_d;
  logic [ALU_W-1:0]  result_q, result_d;
  logic              div0_q, div0_d;
  logic              ill_q, ill_d;
  logic [ALU_W-1:0]  regs_q [NREGS];
  logic [ALU_W-1:0]  regs_d [NREGS];

  logic [ALU_W-1:0]   alu_o;
  logic [2*ALU_W-1:0] alu_product;
  logic [ALU_W-1:0]   alu_remainder;

  alu u_alu (
    .x         (a_q),
    .y         (b_q),
    .opcode    (op_q),
    .o         (alu_o),
    .product   (alu_product),
    .remainder (alu_remainder)
  );

  assign in_ready = (state_q == ST_IDLE) && !rst;
  assign rd_data  = regs_q[rd_addr];
  assign result   = result_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    dst_d       = dst_q;
    imm_d       = imm_q;
    a_d         = a_q;
    b_d         = b_q;
    res_lo_d    = res_lo_q;
    res_hi_d    = res_hi_q;
    result_d    = result_q;
    div0_d      = div0_q;
    ill_d       = ill_q;
    regs_d      = regs_q;
    done        = 1'b0;
    err_div0    = 1'b0;
    err_illegal = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          op_d    = in_op;
          dst_d   = in_dst;
          imm_d   = in_imm;
          a_d     = regs_q[in_src_a];
          b_d     = regs_q[in_src_b];
          div0_d  = (in_op == OP_DIV) && (regs_q[in_src_b] == '0);
          ill_d   = is_illegal(in_op);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (op_q == OP_LDI)      res_lo_d = imm_q;
        else if (op_q == OP_MUL) res_lo_d = alu_product[ALU_W-1:0];
        else                     res_lo_d = alu_o;
        res_hi_d = (op_q == OP_MUL) ? alu_product[2*ALU_W-1:ALU_W] : alu_remainder;
        state_d  = ST_WB1;
      end
      ST_WB1: begin
        // Faulted instructions retire here without touching any register.
        if (div0_q || ill_q) begin
          done        = 1'b1;
          err_div0    = div0_q;
          err_illegal = ill_q;
          state_d     = ST_IDLE;
        end else begin
          regs_d[dst_q] = res_lo_q;
          result_d      = res_lo_q;
          if (writes_two(op_q)) begin
            state_d = ST_WB2;
          end else begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_WB2: begin
        regs_d[dst_q + RA_W'(1)] = res_hi_q;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A reset cycle aborts the instruction, so no retire is reported.
    if (rst) begin
      done        = 1'b0;
      err_div0    = 1'b0;
      err_illegal = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      dst_q    <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      result_q <= '0;
      div0_q   <= 1'b0;
      ill_q    <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      imm_q    <= imm_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      result_q <= result_d;
      div0_q   <= div0_d;
      ill_q    <= ill_d;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: loads, MUL/DIV double writes, error
// retires, back-to-back hand-off and reset in the middle of a MUL.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [1:0] in_dst;
  logic [1:0] in_src_a;
  logic [1:0] in_src_b;
  logic [3:0] in_imm;
  logic [1:0] rd_addr;
  logic [3:0] rd_data;
  logic       done;
  logic [3:0] result;
  logic       err_div0;
  logic       err_illegal;

  int checks = 0;
  int errors = 0;

  alu_sequencer #(.NREGS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_dst      (in_dst),
    .in_src_a    (in_src_a),
    .in_src_b    (in_src_b),
    .in_imm      (in_imm),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .done        (done),
    .result      (result),
    .err_div0    (err_div0),
    .err_illegal (err_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reg_chk(input string tag, input logic [1:0] r, input logic [3:0] exp);
    rd_addr = r;
    #1;
    check(tag, {4'h0, rd_data}, {4'h0, exp});
  endtask

  // Issues one instruction and returns cycles from accept to done (99 if none).
  task automatic exec(input logic [3:0] op, input logic [1:0] d, input logic [1:0] a,
                      input logic [1:0] b, input logic [3:0] imm,
                      output int lat, output logic e0, output logic ei);
    int  w;
    logic seen;
    @(negedge clk);
    in_op = op; in_dst = d; in_src_a = a; in_src_b = b; in_imm = imm;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) check("ready_timeout", {7'd0, in_ready}, 8'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0; e0 = 1'b0; ei = 1'b0; seen = 1'b0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      lat++;
      if (done) begin
        seen = 1'b1;
        e0 = err_div0;
        ei = err_illegal;
      end
    end
    if (!seen) lat = 99;
  endtask

  task automatic load(input int k);
    in_imm = 4'd0;
    case (k)
      0:       begin in_op = OP_ADD; in_dst = 2'd2; in_src_a = 2'd3; in_src_b = 2'd1; end
      1:       begin in_op = OP_XOR; in_dst = 2'd0; in_src_a = 2'd2; in_src_b = 2'd3; end
      default: begin in_op = OP_NOT; in_dst = 2'd1; in_src_a = 2'd0; in_src_b = 2'd0; end
    endcase
  endtask

  initial begin
    int   lat;
    logic e0, ei;
    int   acc [3];
    int   k, cyc, ndone;

    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_dst = '0;
    in_src_a = '0; in_src_b = '0; in_imm = '0; rd_addr = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {7'd0, in_ready}, 8'd0);
    check("rst_done", {7'd0, done}, 8'd0);
    check("rst_result", {4'd0, result}, 8'd0);
    for (int i = 0; i < 4; i++) reg_chk("rst_reg", 2'(i), 4'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {7'd0, in_ready}, 8'd1);

    // Load and multiply: 15 * 15 = 225 = 0xE1
    exec(OP_LDI, 2'd0, 2'd0, 2'd0, 4'd15, lat, e0, ei);
    check("ldi_lat", 8'(lat), 8'd2);
    exec(OP_LDI, 2'd1, 2'd0, 2'd0, 4'd15, lat, e0, ei);
    exec(OP_MUL, 2'd2, 2'd0, 2'd1, 4'd0, lat, e0, ei);
    check("mul_lat", 8'(lat), 8'd3);
    check("mul_result", {4'd0, result}, 8'h01);
    @(negedge clk);
    reg_chk("mul_lo", 2'd2, 4'h1);
    reg_chk("mul_hi", 2'd3, 4'hE);

    // Divide: 15 / 15 = 1 rem 0; remainder wraps from r3 into r0
    exec(OP_DIV, 2'd3, 2'd0, 2'd1, 4'd0, lat, e0, ei);
    check("div_lat", 8'(lat), 8'd3);
    check("div_err", {6'd0, e0, ei}, 8'd0);
    check("div_result", {4'd0, result}, 8'h01);
    @(negedge clk);
    reg_chk("div_q", 2'd3, 4'h1);
    reg_chk("div_rem_wrap", 2'd0, 4'h0);
    reg_chk("div_r1", 2'd1, 4'hF);

    // Division by zero: r0=0 r1=0 r2=1 r3=1 afterwards
    exec(OP_LDI, 2'd1, 2'd0, 2'd0, 4'd0, lat, e0, ei);
    exec(OP_DIV, 2'd2, 2'd2, 2'd1, 4'd0, lat, e0, ei);
    check("div0_lat", 8'(lat), 8'd2);
    check("div0_flags", {6'd0, e0, ei}, 8'b10);
    @(negedge clk);
    reg_chk("div0_r0", 2'd0, 4'h0);
    reg_chk("div0_r1", 2'd1, 4'h0);
    reg_chk("div0_r2", 2'd2, 4'h1);
    reg_chk("div0_r3", 2'd3, 4'h1);

    // Illegal opcode leaves r3 and result alone
    exec(OP_LDI, 2'd3, 2'd0, 2'd0, 4'd9, lat, e0, ei);
    exec(4'd13, 2'd3, 2'd0, 2'd1, 4'd5, lat, e0, ei);
    check("ill_lat", 8'(lat), 8'd2);
    check("ill_flags", {6'd0, e0, ei}, 8'b01);
    @(negedge clk);
    reg_chk("ill_r3", 2'd3, 4'h9);
    check("ill_result", {4'd0, result}, 8'h09);

    // Add wrap: 15 + 1 = 0
    exec(OP_LDI, 2'd0, 2'd0, 2'd0, 4'd15, lat, e0, ei);
    exec(OP_LDI, 2'd1, 2'd0, 2'd0, 4'd1, lat, e0, ei);
    exec(OP_ADD, 2'd2, 2'd0, 2'd1, 4'd0, lat, e0, ei);
    check("add_lat", 8'(lat), 8'd2);
    @(negedge clk);
    reg_chk("add_wrap", 2'd2, 4'h0);
    check("add_result", {4'd0, result}, 8'h00);

    // Back-to-back with in_valid held: r2=9+1=A, r0=A^9=3, r1=~3=C
    @(negedge clk);
    in_valid = 1'b1;
    load(0);
    k = 0; cyc = 0;
    while (k < 3 && cyc < 40) begin
      if (in_ready) begin
        acc[k] = cyc;
        k++;
      end
      @(posedge clk);
      #1;
      if (k < 3) load(k);
      else in_valid = 1'b0;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("b2b_count", 8'(k), 8'd3);
    check("b2b_gap1", 8'(acc[1] - acc[0]), 8'd3);
    check("b2b_gap2", 8'(acc[2] - acc[1]), 8'd3);
    repeat (3) @(negedge clk);
    reg_chk("b2b_add", 2'd2, 4'hA);
    reg_chk("b2b_xor", 2'd0, 4'h3);
    reg_chk("b2b_not", 2'd1, 4'hC);

    // Reset during EXEC of a MUL: nothing written, registers cleared
    @(negedge clk);
    in_op = OP_MUL; in_dst = 2'd2; in_src_a = 2'd0; in_src_b = 2'd1; in_valid = 1'b1;
    check("rmul_ready", {7'd0, in_ready}, 8'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rmul_ready_in_rst", {7'd0, in_ready}, 8'd0);
    ndone = (done === 1'b1) ? 1 : 0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rmul_ready_after", {7'd0, in_ready}, 8'd1);
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    check("rmul_no_done", 8'(ndone), 8'd0);
    for (int i = 0; i < 4; i++) reg_chk("rmul_reg", 2'(i), 4'd0);
    check("rmul_result", {4'd0, result}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
